// File: rtl/cam_dvp_tx_if.sv
// Frame-store read port: one-cycle read strobe and pixel address out, pixel word
// back the following cycle.
interface cam_dvp_tx_if;
  logic        rdreq;
  logic [19:0] rdaddr;
  logic [15:0] rddata;

  modport master (output rdreq, output rdaddr, input rddata);
  modport slave  (input rdreq, input rdaddr, output rddata);
endinterface

// File: rtl/cam_dvp_tx.sv
// DVP-style byte-stream camera transmitter: replays 16-bit pixels from a frame
// store as low/high bytes with vsync/hsync framing and a forwarded pixel clock.
module cam_dvp_tx #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned VSYNC_LEN = 3,
  parameter int unsigned V_BACK    = 17,
  parameter int unsigned V_FRONT   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  cam_dvp_tx_if.master        mem,
  output logic                csi_pclk,
  output logic [7:0]          csi_data,
  output logic                csi_vsync,
  output logic                csi_hsync,
  output logic                frame_done
);
  localparam int unsigned AB = 2 * H_ACTIVE;
  localparam int unsigned L  = AB + H_BLANK;
  localparam int unsigned CW = $clog2(L);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [15:0]   r_line;
  logic [19:0]   r_addr;
  logic [7:0]    r_hold;
  logic          r_run;
  logic          r_done_d;

  logic          w_eol;
  logic          w_last_line;
  logic          w_active_byte;
  logic          w_req;

  // All outputs are registered from the current state position, so the whole
  // output stream trails the state counters by exactly one cycle.
  always_comb begin
    w_eol         = (r_col == CW'(L - 1));
    w_active_byte = (r_state == ACTIVE) && (r_col < CW'(AB));
    case (r_state)
      VSYNC:   w_last_line = (r_line == 16'(VSYNC_LEN - 1));
      VBACK:   w_last_line = (r_line == 16'(V_BACK - 1));
      ACTIVE:  w_last_line = (r_line == 16'(V_ACTIVE - 1));
      VFRONT:  w_last_line = (r_line == 16'(V_FRONT - 1));
      default: w_last_line = 1'b0;
    endcase
    w_req = 1'b0;
    // Pixel 0 of a line is fetched two cycles before the line starts.
    if (r_state == VBACK && w_last_line && r_col == CW'(L - 2))
      w_req = 1'b1;
    if (r_state == ACTIVE) begin
      if (r_col < CW'(AB - 2) && !r_col[0])
        w_req = 1'b1;
      if (r_col == CW'(L - 2) && !w_last_line)
        w_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_line     <= '0;
      r_addr     <= '0;
      r_hold     <= '0;
      r_run      <= 1'b0;
      r_done_d   <= 1'b0;
      csi_data   <= '0;
      csi_vsync  <= 1'b0;
      csi_hsync  <= 1'b0;
      frame_done <= 1'b0;
      mem.rdreq  <= 1'b0;
      mem.rdaddr <= '0;
    end else begin
      csi_vsync  <= (r_state == VSYNC);
      csi_hsync  <= w_active_byte;
      r_run      <= (r_state != IDLE);
      frame_done <= r_done_d;
      r_done_d   <= 1'b0;
      mem.rdreq  <= w_req;

      // Low byte bypasses the holding register; the word arrives on this cycle.
      csi_data <= '0;
      if (w_active_byte) begin
        if (r_col[0]) begin
          csi_data <= r_hold;
        end else begin
          csi_data <= mem.rddata[7:0];
          r_hold   <= mem.rddata[15:8];
        end
      end

      if (w_req) begin
        mem.rdaddr <= r_addr;
        r_addr     <= r_addr + 20'd1;
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= VSYNC;
            r_col   <= '0;
            r_line  <= '0;
            r_addr  <= '0;
          end
        end
        default: begin
          r_col <= w_eol ? '0 : r_col + 1'b1;
          if (w_eol) begin
            r_line <= w_last_line ? '0 : r_line + 16'd1;
            if (w_last_line) begin
              case (r_state)
                VSYNC:  r_state <= VBACK;
                VBACK:  r_state <= ACTIVE;
                ACTIVE: r_state <= VFRONT;
                VFRONT: begin
                  r_done_d <= 1'b1;
                  r_addr   <= '0;
                  r_state  <= enable ? VSYNC : IDLE;
                end
                default: r_state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign csi_pclk = r_run ? ~clk : 1'b0;
endmodule

// File: tb/tb_cam_dvp_tx.sv
// Bench for cam_dvp_tx on a 4x2 frame: positional frame-timing model plus a
// byte scoreboard filled by the frame-store model as it answers read strobes.
module tb_cam_dvp_tx;
  localparam int HA = 4, VA = 2, HB = 3, VS = 2, VB = 1, VF = 1;
  localparam int L      = 2 * HA + HB;
  localparam int ACT0   = (VS + VB) * L;
  localparam int FRAME  = (VS + VB + VA + VF) * L;
  localparam int IDLE_P = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       csi_pclk, csi_vsync, csi_hsync, frame_done;
  logic [7:0] csi_data;

  cam_dvp_tx_if mem();

  cam_dvp_tx #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .VSYNC_LEN(VS),
    .V_BACK   (VB),
    .V_FRONT  (VF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem       (mem.master),
    .csi_pclk  (csi_pclk),
    .csi_data  (csi_data),
    .csi_vsync (csi_vsync),
    .csi_hsync (csi_hsync),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  logic [7:0]  sb[$];
  logic [15:0] mem_word;
  int          p = IDLE_P, prev_p = IDLE_P, nfr = 0;
  logic [19:0] exp_pix = '0;
  logic        vs_prev = 1'b0, rst_prev = 1'b1, hs_e;
  logic [7:0]  eb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit exp_req_at(input int pos);
    for (int k = 0; k < HA * VA; k++)
      if (pos == ACT0 + (k / HA) * L + 2 * (k % HA) - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_hs_at(input int pos);
    return pos >= ACT0 && pos < ACT0 + VA * L && ((pos - ACT0) % L) < 2 * HA;
  endfunction

  // Frame store: word valid the cycle after the strobe; its bytes are the
  // expected stream, in wire order.
  always @(posedge clk) begin
    if (mem.rdreq === 1'b1) begin
      mem_word = 16'hA000 | mem.rdaddr[15:0];
      mem.rddata <= mem_word;
      sb.push_back(mem_word[7:0]);
      sb.push_back(mem_word[15:8]);
    end
  end

  always @(negedge clk) begin
    prev_p = p;
    if (rst_prev) begin
      p = IDLE_P;
      sb.delete();
    end else if (csi_vsync && !vs_prev) begin
      p = 0;
      exp_pix = '0;
    end else if (p < IDLE_P) begin
      p++;
    end
    hs_e = exp_hs_at(p);
    check("vsync", csi_vsync, p < VS * L);
    check("hsync", csi_hsync, hs_e);
    check("rdreq", mem.rdreq, exp_req_at(p));
    check("frame_done", frame_done, (p == FRAME) || (p == 0 && prev_p == FRAME - 1));
    check("pclk", csi_pclk, p < FRAME);
    if (hs_e) begin
      check("data_avail", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        eb = sb.pop_front();
        check("data", csi_data, eb);
      end
    end else begin
      check("data_blank", csi_data, 0);
    end
    if (mem.rdreq === 1'b1) begin
      check("rdaddr", mem.rdaddr, exp_pix);
      exp_pix++;
    end
    if (p == FRAME - 1) nfr++;
    vs_prev  = csi_vsync;
    rst_prev = reset;
  end

  initial begin
    int unsigned n;
    int          nfr0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdaddr", mem.rdaddr, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b1;
    n = 0;
    while (!csi_vsync && n < 10) begin @(posedge clk); #1; n++; end
    check("vsync_start_lat", n, 2);

    n = 0;
    while (nfr < 2 && n < 300) begin @(posedge clk); #1; n++; end
    check("two_frames", nfr >= 2, 1);

    // Drop enable during the second active line of the third frame.
    n = 0;
    while (p != ACT0 + L + 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("reach_line1", p, ACT0 + L + 2);
    enable = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("frame_completed", nfr, 3);
    check("idle_pclk", csi_pclk, 0);

    // Reset while the third byte of line 0 is on the wire.
    enable = 1'b1;
    n = 0;
    while (p != ACT0 + 1 && n < 200) begin @(posedge clk); #1; n++; end
    check("reach_byte2", p, ACT0 + 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_outs", {csi_data, csi_vsync, csi_hsync, mem.rdreq, frame_done, csi_pclk}, 0);
    check("rst_rdaddr_mid", mem.rdaddr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nfr0 = nfr;
    n = 0;
    while (p != 10 && n < 50) begin @(posedge clk); #1; n++; end
    check("fresh_vsync", p, 10);
    enable = 1'b0;
    n = 0;
    while (nfr == nfr0 && n < 200) begin @(posedge clk); #1; n++; end
    check("frame_after_rst", nfr, nfr0 + 1);
    repeat (30) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    check("final_rdreq", mem.rdreq, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
